// File: rtl/dvi_link_sequencer.sv
// DVI link bring-up: qualify both PLL locks, pulse serializer/timing resets, blank then active video.
// Optional frame watchdog enabled by defining DVI_SEQ_WATCHDOG_EN.
module dvi_link_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned SER_RESET_CYCLES   = 16,
  parameter int unsigned BLANK_FRAMES       = 2,
  parameter int unsigned FRAME_TIMEOUT      = 2000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       pll_lock,
  input  logic       pll_lock_ser,
  input  logic       frame_start,
  input  logic       relock_clear,
  output logic       ser_reset,
  output logic       timing_reset,
  output logic       video_active,
  output logic       link_up,
  output logic [2:0] state,
  output logic [7:0] relock_count,
  output logic       wdt_fault
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_LOCK    = 3'd1,
    SER_RESET    = 3'd2,
    TIMING_START = 3'd3,
    BLANK        = 3'd4,
    ACTIVE       = 3'd5
  } state_t;

  localparam int unsigned M1 =
    (LOCK_STABLE_CYCLES > SER_RESET_CYCLES) ?
    LOCK_STABLE_CYCLES : SER_RESET_CYCLES;
  localparam int unsigned M2 =
    (M1 > BLANK_FRAMES) ? M1 : BLANK_FRAMES;
  localparam int unsigned CW = $clog2(M2 + 1);

  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SER_LAST   = CW'(SER_RESET_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_FRAMES - 1);

  state_t        cur;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    sync_pix;
  logic [1:0]    sync_ser;
  logic          lock_ok;
  logic          lock_loss;
  logic          wdt_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_pix <= '0;
      sync_ser <= '0;
    end else begin
      sync_pix <= {sync_pix[0], pll_lock};
      sync_ser <= {sync_ser[0], pll_lock_ser};
    end
  end

  assign lock_ok = sync_pix[1] & sync_ser[1];

  always_comb begin
    nxt       = cur;
    lock_loss = 1'b0;
    if (!enable) begin
      nxt = IDLE;
    end else if (!lock_ok && cur >= SER_RESET) begin
      nxt       = WAIT_LOCK;
      lock_loss = 1'b1;
    end else if (wdt_hit) begin
      nxt = SER_RESET;
    end else begin
      unique case (cur)
        IDLE:         nxt = WAIT_LOCK;
        WAIT_LOCK:    if (lock_ok && cnt == LOCK_LAST) nxt = SER_RESET;
        SER_RESET:    if (cnt == SER_LAST) nxt = TIMING_START;
        TIMING_START: nxt = BLANK;
        BLANK:        if (frame_start && cnt == BLANK_LAST) nxt = ACTIVE;
        ACTIVE:       nxt = ACTIVE;
        default:      nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur <= IDLE;
    else       cur <= nxt;
  end

  // One shared counter: lock stability, reset length or blank frames.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (nxt != cur) begin
      cnt <= '0;
    end else begin
      unique case (cur)
        WAIT_LOCK: cnt <= lock_ok ? cnt + 1'b1 : '0;
        SER_RESET: cnt <= cnt + 1'b1;
        BLANK:     if (frame_start) cnt <= cnt + 1'b1;
        default:   cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      relock_count <= '0;
    else if (relock_clear)
      relock_count <= {7'd0, lock_loss};
    else if (lock_loss && relock_count != 8'hFF)
      relock_count <= relock_count + 1'b1;
  end

`ifdef DVI_SEQ_WATCHDOG_EN
  localparam int unsigned WW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(FRAME_TIMEOUT - 1);

  logic [WW-1:0] wdt_cnt;
  logic          wdt_flag;
  logic          in_video;
  logic          wdt_trip;

  assign in_video = (cur == BLANK) || (cur == ACTIVE);
  assign wdt_hit  = in_video && !frame_start && wdt_cnt == WDT_LAST;
  assign wdt_trip = wdt_hit && enable && lock_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdt_cnt  <= '0;
      wdt_flag <= 1'b0;
    end else begin
      if (nxt != cur || frame_start) wdt_cnt <= '0;
      else if (in_video)             wdt_cnt <= wdt_cnt + 1'b1;
      if (wdt_trip)          wdt_flag <= 1'b1;
      else if (relock_clear) wdt_flag <= 1'b0;
    end
  end

  assign wdt_fault = wdt_flag;
`else
  assign wdt_hit   = 1'b0;
  assign wdt_fault = 1'b0;
`endif

  assign state = cur;

  always_comb begin
    ser_reset    = 1'b1;
    timing_reset = 1'b1;
    video_active = 1'b0;
    link_up      = 1'b0;
    unique case (1'b1)
      (cur == TIMING_START): ser_reset = 1'b0;
      (cur == BLANK): begin
        ser_reset    = 1'b0;
        timing_reset = 1'b0;
      end
      (cur == ACTIVE): begin
        ser_reset    = 1'b0;
        timing_reset = 1'b0;
        video_active = 1'b1;
        link_up      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dvi_link_sequencer.sv
// Bench for dvi_link_sequencer with short lock/reset/timeout parameters.
// Scoreboard queues hold expected state segments and relock counts.
module tb_dvi_link_sequencer;

  localparam int L = 8;
  localparam int S = 4;
  localparam int B = 2;
  localparam int T = 100;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       pll_lock;
  logic       pll_lock_ser;
  logic       frame_start;
  logic       relock_clear;
  logic       ser_reset;
  logic       timing_reset;
  logic       video_active;
  logic       link_up;
  logic [2:0] state;
  logic [7:0] relock_count;
  logic       wdt_fault;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] st;
    int         len;
  } seg_t;

  seg_t       seg_q[$];
  logic [7:0] rc_q[$];

  dvi_link_sequencer #(
    .LOCK_STABLE_CYCLES(L),
    .SER_RESET_CYCLES(S),
    .BLANK_FRAMES(B),
    .FRAME_TIMEOUT(T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .pll_lock(pll_lock),
    .pll_lock_ser(pll_lock_ser),
    .frame_start(frame_start),
    .relock_clear(relock_clear),
    .ser_reset(ser_reset),
    .timing_reset(timing_reset),
    .video_active(video_active),
    .link_up(link_up),
    .state(state),
    .relock_count(relock_count),
    .wdt_fault(wdt_fault)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] exp_out(input logic [2:0] s);
    case (s)
      3'd3:    return 4'b0100;
      3'd4:    return 4'b0000;
      3'd5:    return 4'b0011;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic logic [3:0] act_out();
    return {ser_reset, timing_reset, video_active, link_up};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic measure(input logic [2:0] st, output int n);
    n = 0;
    while (state === st && n < 400) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int lim,
                            output bit ok);
    int n = 0;
    while (state !== st && n < lim) begin
      tick();
      n++;
    end
    ok = (state === st);
  endtask

  task automatic do_reset(input logic lk);
    reset        = 1'b1;
    enable       = 1'b0;
    pll_lock     = lk;
    pll_lock_ser = lk;
    frame_start  = 1'b0;
    relock_clear = 1'b0;
    tick(2);
    reset = 1'b0;
    tick();
  endtask

  task automatic bring_up(output bit ok);
    bit w;
    pll_lock     = 1'b1;
    pll_lock_ser = 1'b1;
    enable       = 1'b1;
    wait_state(3'd4, 200, w);
    ok = w;
    if (w) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      wait_state(3'd5, 5, w);
      ok = w;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    enable       = 1'b0;
    pll_lock     = 1'b0;
    pll_lock_ser = 1'b0;
    frame_start  = 1'b0;
    relock_clear = 1'b0;
    tick(2);
    n_tests++;
    if (state !== 3'd0 || act_out() !== 4'b1100 ||
        relock_count !== 8'd0 || wdt_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d out=%b rc=%0d wdt=%b want 0 1100 0 0",
               state, act_out(), relock_count, wdt_fault);
    end
    reset = 1'b0;
    tick(3);
    n_tests++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_hold: state=%0d want 0", state);
    end
  endtask

  task automatic test_bringup();
    seg_t e;
    int   n;
    do_reset(1'b0);
    seg_q.push_back('{st: 3'd1, len: 2 + L});
    seg_q.push_back('{st: 3'd2, len: S});
    seg_q.push_back('{st: 3'd3, len: 1});
    enable = 1'b1;
    tick();
    pll_lock     = 1'b1;
    pll_lock_ser = 1'b1;
    while (seg_q.size() > 0) begin
      e = seg_q.pop_front();
      n_tests++;
      if (state !== e.st || act_out() !== exp_out(e.st)) begin
        n_fail++;
        $display("FAIL seg_entry: state=%0d out=%b want %0d %b",
                 state, act_out(), e.st, exp_out(e.st));
      end
      measure(e.st, n);
      n_tests++;
      if (n != e.len) begin
        n_fail++;
        $display("FAIL seg_len: state %0d lasted %0d want %0d",
                 e.st, n, e.len);
      end
    end
    n_tests++;
    if (state !== 3'd4 || act_out() !== 4'b0000) begin
      n_fail++;
      $display("FAIL blank_entry: state=%0d out=%b want 4 0000",
               state, act_out());
    end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    n_tests++;
    if (state !== 3'd4) begin
      n_fail++;
      $display("FAIL blank_first_frame: state=%0d want 4", state);
    end
    tick(2);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    n_tests++;
    if (state !== 3'd5 || act_out() !== 4'b0011) begin
      n_fail++;
      $display("FAIL active_entry: state=%0d out=%b want 5 0011",
               state, act_out());
    end
  endtask

  task automatic test_lock_glitch();
    int c;
    do_reset(1'b1);
    tick(3);
    enable = 1'b1;
    tick();
    c = 0;
    while (state === 3'd1 && c < 100) begin
      if (c == 5) pll_lock_ser = 1'b0;
      if (c == 6) pll_lock_ser = 1'b1;
      c++;
      tick();
    end
    n_tests++;
    if (c != 6 + 2 + L || state !== 3'd2 || relock_count !== 8'd0) begin
      n_fail++;
      $display("FAIL lock_glitch: wait=%0d state=%0d rc=%0d want %0d 2 0",
               c, state, relock_count, 6 + 2 + L);
    end
  endtask

  task automatic test_relock_saturate();
    bit         ok;
    logic [7:0] exp_rc;
    logic [7:0] want;
    exp_rc = 8'd0;
    bring_up(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL relock_bringup: state=%0d want 5", state);
    end
    pll_lock = 1'b0;
    exp_rc   = exp_rc + 8'd1;
    rc_q.push_back(exp_rc);
    tick(2);
    n_tests++;
    if (state !== 3'd5) begin
      n_fail++;
      $display("FAIL relock_sync_delay: state=%0d want 5", state);
    end
    tick();
    want = rc_q.pop_front();
    n_tests++;
    if (state !== 3'd1 || ser_reset !== 1'b1 || relock_count !== want) begin
      n_fail++;
      $display("FAIL relock_active: state=%0d ser=%b rc=%0d want 1 1 %0d",
               state, ser_reset, relock_count, want);
    end
    for (int i = 0; i < 255; i++) begin
      pll_lock = 1'b1;
      wait_state(3'd2, 60, ok);
      pll_lock = 1'b0;
      exp_rc = (exp_rc == 8'hFF) ? exp_rc : exp_rc + 8'd1;
      rc_q.push_back(exp_rc);
      if (ok) wait_state(3'd1, 10, ok);
      want = rc_q.pop_front();
      n_tests++;
      if (!ok || relock_count !== want) begin
        n_fail++;
        $display("FAIL relock_event %0d: state=%0d rc=%0d want 1 %0d",
                 i, state, relock_count, want);
        break;
      end
    end
    n_tests++;
    if (relock_count !== 8'd255) begin
      n_fail++;
      $display("FAIL relock_saturate: rc=%0d want 255", relock_count);
    end
    pll_lock = 1'b1;
    wait_state(3'd2, 60, ok);
    pll_lock = 1'b0;
    tick(2);
    relock_clear = 1'b1;
    tick();
    relock_clear = 1'b0;
    n_tests++;
    if (!ok || state !== 3'd1 || relock_count !== 8'd1) begin
      n_fail++;
      $display("FAIL clear_with_event: state=%0d rc=%0d want 1 1",
               state, relock_count);
    end
    tick();
    relock_clear = 1'b1;
    tick();
    relock_clear = 1'b0;
    n_tests++;
    if (relock_count !== 8'd0) begin
      n_fail++;
      $display("FAIL clear_plain: rc=%0d want 0", relock_count);
    end
  endtask

  task automatic test_enable_blank();
    bit ok;
    pll_lock = 1'b1;
    wait_state(3'd4, 200, ok);
    pll_lock = 1'b0;
    tick(2);
    n_tests++;
    if (!ok || state !== 3'd4) begin
      n_fail++;
      $display("FAIL enable_blank_pre: state=%0d want 4", state);
    end
    enable = 1'b0;
    tick();
    n_tests++;
    if (state !== 3'd0 || relock_count !== 8'd0 || ser_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_over_loss: state=%0d rc=%0d ser=%b want 0 0 1",
               state, relock_count, ser_reset);
    end
  endtask

  task automatic test_reset_active();
    bit ok;
    bring_up(ok);
    pll_lock = 1'b0;
    wait_state(3'd1, 10, ok);
    bring_up(ok);
    n_tests++;
    if (!ok || relock_count !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_pre: state=%0d rc=%0d want 5 1",
               state, relock_count);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (state !== 3'd0 || act_out() !== 4'b1100 ||
        relock_count !== 8'd0 || wdt_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: state=%0d out=%b rc=%0d want 0 1100 0",
               state, act_out(), relock_count);
    end
    tick(2);
    reset = 1'b0;
    bring_up(ok);
    n_tests++;
    if (!ok || link_up !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_after_reset: state=%0d link=%b want 5 1",
               state, link_up);
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    int n;
    enable = 1'b0;
    tick();
    bring_up(ok);
`ifdef DVI_SEQ_WATCHDOG_EN
    measure(3'd5, n);
    n_tests++;
    if (!ok || n != T || state !== 3'd2 || wdt_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL watchdog_trip: active=%0d state=%0d wdt=%b want %0d 2 1",
               n, state, wdt_fault, T);
    end
    wait_state(3'd4, 20, ok);
    n_tests++;
    if (!ok || wdt_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL watchdog_sticky: state=%0d wdt=%b want 4 1",
               state, wdt_fault);
    end
    relock_clear = 1'b1;
    tick();
    relock_clear = 1'b0;
    n_tests++;
    if (wdt_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL watchdog_clear: wdt=%b want 0", wdt_fault);
    end
`else
    tick(T + 50);
    n = 0;
    n_tests++;
    if (!ok || state !== 3'd5 || wdt_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL no_watchdog: state=%0d wdt=%b want 5 0 (%0d)",
               state, wdt_fault, n);
    end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_bringup();
    test_lock_glitch();
    test_relock_saturate();
    test_enable_blank();
    test_reset_active();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
